// File: rtl/fifod2mac.sv
// Transmit bridge: waits for fifod to hold a full payload, starts one UDP frame on the mac
// and answers each per-byte request with a fifod byte (or a 0x00 pad) one cycle later.
module fifod2mac #(
   parameter int LEN_W   = 12,
   parameter int CNT_W   = 12,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fs,
   output logic             fd,
   output logic             err,
   input  logic [LEN_W-1:0] tx_len,
   input  logic [CNT_W-1:0] fifod_rd_count,
   input  logic             fifod_empty,
   output logic             fifod_rxen,
   input  logic [7:0]       fifod_rxd,
   output logic             fs_udp_tx,
   input  logic             fd_udp_tx,
   output logic [LEN_W-1:0] udp_tx_len,
   input  logic             flag_udp_tx_req,
   output logic             udp_txen,
   output logic [7:0]       udp_txd,
   output logic [2:0]       dbg_state
);

   localparam int TMR_W = $clog2(TIMEOUT + 1) + 1;
   localparam int CMP_W = (LEN_W > CNT_W) ? LEN_W : CNT_W;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_START   = 3'd2,
      S_SEND    = 3'd3,
      S_WAIT_FD = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               err_q, err_d;
   logic               fd_q, fd_d;
   logic               txen_q, txen_d;
   logic               rd_q, rd_d;
   logic               fd_seen_q, fd_seen_d;
   logic               rxen;
   logic               in_stream;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         timer_q   <= '0;
         err_q     <= 1'b0;
         fd_q      <= 1'b0;
         txen_q    <= 1'b0;
         rd_q      <= 1'b0;
         fd_seen_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
         fd_q      <= fd_d;
         txen_q    <= txen_d;
         rd_q      <= rd_d;
         fd_seen_q <= fd_seen_d;
      end
   end

   // Handshake: every cycle flag_udp_tx_req is high while streaming, the mac gets exactly one
   // byte with udp_txen high on the following cycle; there is no back-pressure toward the mac.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      err_d     = err_q;
      fd_seen_d = fd_seen_q;
      txen_d    = 1'b0;
      rd_d      = 1'b0;
      rxen      = 1'b0;
      in_stream = (state_q == S_SEND) || (state_q == S_WAIT_FD);

      if (in_stream) begin
         timer_d = timer_q + TMR_W'(1);
         if (flag_udp_tx_req) begin
            txen_d = 1'b1;
            if (cnt_q < len_q) cnt_d = cnt_q + LEN_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (fs) begin
               len_d   = tx_len;
               err_d   = 1'b0;
               state_d = (tx_len == '0) ? S_DONE : S_CHECK;
            end
         end
         S_CHECK: begin
            if (CMP_W'(fifod_rd_count) >= CMP_W'(len_q)) state_d = S_START;
         end
         S_START: begin
            cnt_d     = '0;
            timer_d   = '0;
            fd_seen_d = 1'b0;
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (flag_udp_tx_req && (cnt_q < len_q)) begin
               if (!fifod_empty) begin
                  rxen = 1'b1;
                  rd_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            // An early fd from the mac is remembered so WAIT_FD does not need a second one.
            if (fd_udp_tx) fd_seen_d = 1'b1;
            if ((cnt_q == len_q) || fd_udp_tx) state_d = S_WAIT_FD;
         end
         S_WAIT_FD: begin
            if (fd_udp_tx || fd_seen_q) state_d = S_DONE;
         end
         S_DONE: begin
            if (!fs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (in_stream && (timer_q == TMR_W'(TIMEOUT))) begin
         err_d   = 1'b1;
         state_d = S_DONE;
      end

      fd_d = (state_d == S_DONE);
   end

   assign fd         = fd_q;
   assign err        = err_q;
   assign fifod_rxen = rxen;
   assign fs_udp_tx  = (state_q == S_START);
   assign udp_tx_len = len_q;
   assign udp_txen   = txen_q;
   assign udp_txd    = rd_q ? fifod_rxd : 8'h00;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifod2mac.sv
// Directed bench for fifod2mac: fifod read-port model, mac request driver and a byte scoreboard.
module tb_fifod2mac;
  localparam int LEN_W   = 12;
  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 50;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fs = 1'b0;
  logic             fd;
  logic             err;
  logic [LEN_W-1:0] tx_len = '0;
  logic [CNT_W-1:0] fifod_rd_count;
  logic             fifod_empty;
  logic             fifod_rxen;
  logic [7:0]       fifod_rxd = 8'h00;
  logic             fs_udp_tx;
  logic             fd_udp_tx = 1'b0;
  logic [LEN_W-1:0] udp_tx_len;
  logic             flag_udp_tx_req = 1'b0;
  logic             udp_txen;
  logic [7:0]       udp_txd;
  logic [2:0]       dbg_state;

  fifod2mac #(.LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .err(err), .tx_len(tx_len),
    .fifod_rd_count(fifod_rd_count), .fifod_empty(fifod_empty), .fifod_rxen(fifod_rxen),
    .fifod_rxd(fifod_rxd), .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx),
    .udp_tx_len(udp_tx_len), .flag_udp_tx_req(flag_udp_tx_req), .udp_txen(udp_txen),
    .udp_txd(udp_txd), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // fifod read-port model: data appears the cycle after fifod_rxen
  logic [7:0]       mem [0:255];
  int               wr = 0;
  int               rp = 0;
  logic             force_en = 1'b0;
  logic [CNT_W-1:0] force_cnt = '0;
  assign fifod_rd_count = force_en ? force_cnt : CNT_W'(wr - rp);
  assign fifod_empty    = (fifod_rd_count == '0);
  always @(posedge clk) begin
    if (fifod_rxen) begin
      fifod_rxd <= mem[rp % 256];
      rp <= rp + 1;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int rxen_cnt = 0;
  int fsudp_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (fifod_rxen) rxen_cnt++;
    if (fs_udp_tx) fsudp_cnt++;
    if (udp_txen) begin
      if (exp_q.size() == 0) check_eq("spurious_txen", udp_txen, 1'b0);
      else check_eq("udp_txd", udp_txd, exp_q.pop_front());
    end
  end

  // driver tasks (all called at posedge + #1)
  task automatic push_bytes(input logic [7:0] first, input int n, input bit to_exp);
    for (int i = 0; i < n; i++) begin
      mem[wr % 256] = first + 8'(i);
      wr++;
      if (to_exp) exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic start_frame(input logic [LEN_W-1:0] len);
    tx_len = len;
    fs = 1'b1;
  endtask

  task automatic wait_fs_udp(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fs_udp_tx) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("fs_udp_tx_seen", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_reqs(input int n);
    for (int i = 0; i < n; i++) begin
      flag_udp_tx_req = 1'b1;
      @(posedge clk); #1;
    end
    flag_udp_tx_req = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("fd_seen", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic finish_frame();
    repeat (2) @(posedge clk);
    #1 fd_udp_tx = 1'b1;
    @(posedge clk); #1 fd_udp_tx = 1'b0;
    wait_fd(20);
  endtask

  task automatic end_fs();
    fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("fd_cleared", fd, 1'b0);
    check_eq("back_to_idle", dbg_state, ST_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rx, base_fs, n;

    // reset state
    #12;
    check_eq("rst_fd", fd, 1'b0);
    check_eq("rst_txen", udp_txen, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_fs_udp_tx", fs_udp_tx, 1'b0);
    check_eq("rst_rxen", fifod_rxen, 1'b0);
    check_eq("rst_txd", udp_txd, 8'h00);
    check_eq("rst_udp_tx_len", udp_tx_len, 12'd0);
    check_eq("rst_state", dbg_state, ST_IDLE);

    // 16-byte frame, back-to-back requests
    base_rx = rxen_cnt; base_fs = fsudp_cnt;
    push_bytes(8'h00, 16, 1'b1);
    start_frame(12'd16);
    wait_fs_udp(20);
    check_eq("t1_udp_tx_len", udp_tx_len, 12'd16);
    send_reqs(16);
    finish_frame();
    check_eq("t1_err", err, 1'b0);
    check_eq("t1_rxen_count", rxen_cnt - base_rx, 16);
    check_eq("t1_fs_pulses", fsudp_cnt - base_fs, 1);
    end_fs();
    check_eq("t1_exp_drained", exp_q.size(), 0);

    // fifod short of the length until more data arrives
    base_rx = rxen_cnt; base_fs = fsudp_cnt;
    push_bytes(8'hA0, 4, 1'b1);
    start_frame(12'd8);
    repeat (100) @(posedge clk);
    #1;
    check_eq("t2_no_start_yet", fsudp_cnt - base_fs, 0);
    check_eq("t2_in_check", dbg_state, ST_CHECK);
    push_bytes(8'hA4, 4, 1'b1);
    wait_fs_udp(10);
    send_reqs(8);
    finish_frame();
    check_eq("t2_err", err, 1'b0);
    check_eq("t2_rxen_count", rxen_cnt - base_rx, 8);
    end_fs();

    // extra requests beyond the length get pad bytes
    base_rx = rxen_cnt;
    push_bytes(8'h30, 4, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    start_frame(12'd4);
    wait_fs_udp(20);
    send_reqs(6);
    finish_frame();
    check_eq("t3_rxen_count", rxen_cnt - base_rx, 4);
    check_eq("t3_err", err, 1'b0);
    end_fs();
    check_eq("t3_exp_drained", exp_q.size(), 0);

    // underrun after two bytes
    base_rx = rxen_cnt;
    push_bytes(8'h40, 2, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    force_en = 1'b1; force_cnt = 12'd4;
    start_frame(12'd4);
    wait_fs_udp(20);
    send_reqs(2);
    force_cnt = '0;
    send_reqs(2);
    check_eq("t4_err_set", err, 1'b1);
    check_eq("t4_rxen_count", rxen_cnt - base_rx, 2);
    finish_frame();
    check_eq("t4_err_in_done", err, 1'b1);
    end_fs();
    check_eq("t4_err_sticky_idle", err, 1'b1);
    force_en = 1'b0;

    // zero length: done without a frame, err cleared by the accepted fs
    base_fs = fsudp_cnt;
    start_frame(12'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t5_fd", fd, 1'b1);
    check_eq("t5_err_cleared", err, 1'b0);
    check_eq("t5_no_frame", fsudp_cnt - base_fs, 0);
    end_fs();

    // mac never finishes: timeout after TIMEOUT cycles in SEND/WAIT_FD
    base_rx = rxen_cnt;
    force_en = 1'b1; force_cnt = 12'd2;
    start_frame(12'd2);
    wait_fs_udp(20);
    n = 0;
    while (!fd && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_timeout_cycles", n, 52);
    check_eq("t6_err", err, 1'b1);
    check_eq("t6_no_reads", rxen_cnt - base_rx, 0);
    @(posedge clk); #1;
    end_fs();
    force_en = 1'b0;

    // reset in the middle of a 16-byte frame, then a clean frame
    push_bytes(8'h50, 16, 1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h50 + 8'(i));
    start_frame(12'd16);
    wait_fs_udp(20);
    send_reqs(5);
    @(negedge clk);
    flag_udp_tx_req = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("t7_rst_rxen", fifod_rxen, 1'b0);
    check_eq("t7_rst_txen", udp_txen, 1'b0);
    check_eq("t7_rst_txd", udp_txd, 8'h00);
    check_eq("t7_rst_len", udp_tx_len, 12'd0);
    check_eq("t7_rst_state", dbg_state, ST_IDLE);
    flag_udp_tx_req = 1'b0;
    fs = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr = rp;
    @(posedge clk); #1;
    check_eq("t7_exp_after_rst", exp_q.size(), 0);
    base_rx = rxen_cnt;
    push_bytes(8'h60, 3, 1'b1);
    start_frame(12'd3);
    wait_fs_udp(20);
    check_eq("t7_udp_tx_len", udp_tx_len, 12'd3);
    send_reqs(3);
    finish_frame();
    check_eq("t7_err", err, 1'b0);
    check_eq("t7_rxen_count", rxen_cnt - base_rx, 3);
    end_fs();

    // final report
    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
